serial_pe_feeder: RTL
=====================

// Module: serial_pe_feeder
// PURPOSE
//  Upstream stage of serial_pe. Accepts one instruction at a time: line count plus neuron/weight base line addresses.
//  Reads 512-bit neuron and weight lines from two line SRAMs and serialises them into 16-bit element pairs.
//  Drives serial_pe's neuron/weight/ctl/vld_i inputs as one gap-free stream per instruction.
//  serial_pe has no backpressure, so this block prefetches the next line so the stream never stalls.
// PARAMETERS
//  ADDR_W  11  SRAM line-address width; lines wrap modulo 2^ADDR_W
//  LEN_W   8   width of inst_len (instruction length in 32-element lines)
// PORTS
//  clk             in   1       single clock, all logic on posedge
//  rst             in   1       asynchronous, active-high reset
//  inst_vld        in   1       instruction valid
//  inst_rdy        out  1       instruction ready; high only in IDLE
//  inst_len        in   LEN_W   number of 32-element lines to stream
//  inst_nbase      in   ADDR_W  neuron base line address
//  inst_wbase      in   ADDR_W  weight base line address
//  n_rd_en         out  1       neuron SRAM read enable
//  n_rd_addr       out  ADDR_W  neuron SRAM line address
//  n_rd_data       in   512     neuron line; valid the cycle after n_rd_en
//  w_rd_en         out  1       weight SRAM read enable; always equal to n_rd_en
//  w_rd_addr       out  ADDR_W  weight SRAM line address
//  w_rd_data       in   512     weight line; valid the cycle after w_rd_en
//  pe_neuron       out  16      element to serial_pe
//  pe_weight       out  16      element to serial_pe
//  pe_ctl          out  2       [0]=first element of instruction, [1]=last element
//  pe_vld          out  1       element valid (serial_pe vld_i)
//  busy            out  1       high whenever state != IDLE
//  err_len         out  1       one-cycle pulse: zero-length instruction dropped
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE; all counters and buffers=0.
//   Outputs at reset: inst_rdy=1; rd_en=0, rd_addr=0; pe_*=0; busy=0; err_len=0.
//  FSM IDLE -> FETCH -> WAIT -> STREAM -> IDLE.
//   IDLE: inst_rdy=1. On inst_vld:
//    - inst_len!=0: latch len/bases, go to FETCH.
//    - inst_len==0: stay in IDLE; pulse err_len next cycle; no reads, no pe_vld.
//   FETCH: rd_en=1 with addr = base. Go to WAIT.
//   WAIT: sample rd_data at the end of the cycle into cur_n/cur_w; idx=0; lines_left=len. Go to STREAM.
//   STREAM: pe_vld=1 every cycle.
//    - pe_neuron = cur_n[16*(31-idx) +: 16]; element 0 is bits [511:496]. pe_weight is taken the same way from cur_w.
//    - idx==0 and lines_left>1: rd_en=1, addr = previous addr + 1 (mod 2^ADDR_W).
//    - idx==1: sample that read's data into nxt_n/nxt_w.
//    - idx==31 and lines_left>1: cur<=nxt, idx<=0, lines_left-=1; stay in STREAM.
//    - idx==31 and lines_left==1: go to IDLE.
//  Latency: handshake in cycle T; FETCH in T+1; WAIT in T+2; first pe_vld in T+3.
//  Stream length: exactly 32*inst_len contiguous pe_vld cycles, then pe_vld=0.
//  pe_ctl[0]=1 only on the first element; pe_ctl[1]=1 only on the last element. They never coincide, since each line has 32 elements.
//  pe_* are driven from flops through the idx mux only; no combinational path from any input.
//  Next instruction is accepted at the earliest in the cycle after the last pe_vld (IDLE). Instructions are never chained.
//  inst_* are ignored while busy; rd_data is ignored in cycles not following a rd_en.
//  Reset asserted mid-stream: pe_vld and rd_en drop immediately; no partial ctl[1] is issued. The next instruction starts with ctl[0].
// TESTING
//  1. len=1, nbase=0, wbase=0, handshake at T.
//     -> rd_en only in T+1 at addr 0. pe_vld during T+3..T+34.
//     -> ctl=01 at T+3, ctl=10 at T+34, 00 otherwise. Elements match lines MSB-first.
//  2. len=3, nbase=5, wbase=9.
//     -> reads at (5,9), (6,10), (7,11). 96 contiguous pe_vld cycles; ctl[0] on element 0 only, ctl[1] on element 95 only.
//  3. Four instructions with len 1,2,3,4, each presented as soon as inst_rdy.
//     -> inst_rdy=0 while busy. 32/64/96/128 element streams, each opened by ctl[0].
//     -> serial_pe vld_o fires 4 times with the golden results.
//  4. len=0 -> err_len=1 for one cycle; no rd_en, no pe_vld; inst_rdy stays 1.
//  5. nbase=2^ADDR_W-1, len=2 -> second neuron read at addr 0; 64 elements are correct.
//  6. rst pulsed at element 40 of a len=2 instruction.
//     -> pe_vld=0 and busy=0 immediately. A following len=1 instruction produces a clean 32-element stream.

Source files
------------

// File: rtl/serial_pe_feeder.sv
// Streams 512-bit neuron/weight SRAM lines to serial_pe as gap-free 16-bit element pairs.
// The next line is prefetched during the current one, so a multi-line instruction never stalls.
module serial_pe_feeder #(
    parameter int ADDR_W = 11,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_vld,
    output logic              inst_rdy,
    input  logic [LEN_W-1:0]  inst_len,
    input  logic [ADDR_W-1:0] inst_nbase,
    input  logic [ADDR_W-1:0] inst_wbase,
    output logic              n_rd_en,
    output logic [ADDR_W-1:0] n_rd_addr,
    input  logic [511:0]      n_rd_data,
    output logic              w_rd_en,
    output logic [ADDR_W-1:0] w_rd_addr,
    input  logic [511:0]      w_rd_data,
    output logic [15:0]       pe_neuron,
    output logic [15:0]       pe_weight,
    output logic [1:0]        pe_ctl,
    output logic              pe_vld,
    output logic              busy,
    output logic              err_len
);

    typedef enum logic [1:0] {IDLE, FETCH, WAIT, STREAM} state_t;

    localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);
    localparam logic [LEN_W-1:0]  LEN_TWO  = LEN_W'(2);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_t             state;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   lines_left;
    logic [4:0]         idx;
    logic [511:0]       cur_n, cur_w, nxt_n, nxt_w;
    logic               rd_en;

    // NOTE: the line buffers are reset like every other flop so pe_* read zero straight out of reset.
    // NOTE: all state uses non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            len_q      <= '0;
            lines_left <= '0;
            idx        <= '0;
            cur_n      <= '0;
            cur_w      <= '0;
            nxt_n      <= '0;
            nxt_w      <= '0;
            rd_en      <= 1'b0;
            n_rd_addr  <= '0;
            w_rd_addr  <= '0;
            err_len    <= 1'b0;
        end else begin
            rd_en   <= 1'b0;
            err_len <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (inst_vld) begin
                        if (inst_len != '0) begin
                            len_q     <= inst_len;
                            n_rd_addr <= inst_nbase;
                            w_rd_addr <= inst_wbase;
                            rd_en     <= 1'b1;
                            state     <= FETCH;
                        end else begin
                            err_len <= 1'b1;
                        end
                    end
                end
                FETCH: state <= WAIT;
                WAIT: begin
                    cur_n      <= n_rd_data;
                    cur_w      <= w_rd_data;
                    idx        <= '0;
                    lines_left <= len_q;
                    // Prefetch of line 1 must issue during element 0 of line 0.
                    if (len_q > LEN_ONE) begin
                        rd_en     <= 1'b1;
                        n_rd_addr <= n_rd_addr + ADDR_ONE;
                        w_rd_addr <= w_rd_addr + ADDR_ONE;
                    end
                    state <= STREAM;
                end
                STREAM: begin
                    idx <= idx + 5'd1;
                    if (idx == 5'd1 && lines_left > LEN_ONE) begin
                        nxt_n <= n_rd_data;
                        nxt_w <= w_rd_data;
                    end
                    if (idx == 5'd31) begin
                        if (lines_left > LEN_ONE) begin
                            cur_n      <= nxt_n;
                            cur_w      <= nxt_w;
                            lines_left <= lines_left - LEN_ONE;
                            if (lines_left > LEN_TWO) begin
                                rd_en     <= 1'b1;
                                n_rd_addr <= n_rd_addr + ADDR_ONE;
                                w_rd_addr <= w_rd_addr + ADDR_ONE;
                            end
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic       in_stream;
    logic [4:0] sel;

    assign in_stream = (state == STREAM);
    assign sel       = 5'd31 - idx;

    assign n_rd_en   = rd_en;
    assign w_rd_en   = rd_en;
    assign inst_rdy  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign pe_vld    = in_stream;
    assign pe_neuron = in_stream ? cur_n[{sel, 4'b0000} +: 16] : 16'h0000;
    assign pe_weight = in_stream ? cur_w[{sel, 4'b0000} +: 16] : 16'h0000;
    assign pe_ctl[0] = in_stream && (idx == 5'd0)  && (lines_left == len_q);
    assign pe_ctl[1] = in_stream && (idx == 5'd31) && (lines_left == LEN_ONE);

endmodule
